// File: rtl/button_debounce_capture.sv
// Push-button front end: 2-flop synchronizer, per-channel debounce FSM,
// registered press/release strobes and sticky edge-capture bits with irq.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_STABLE    | sample matches button_level; counter held at 0
// ST_COUNTING  | sample differs from button_level; counting toward acceptance
module button_debounce_capture #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit CAPTURE_RELEASE = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] button_in,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] edge_capture,
  input  logic [NUM_BUTTONS-1:0] edge_clear,
  output logic                   irq
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("button_debounce_capture: DEBOUNCE_CYCLES must be at least 2");
  end

  if ((64'd1 << CNT_WIDTH) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_width
    $error("button_debounce_capture: CNT_WIDTH too narrow for DEBOUNCE_CYCLES");
  end

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  localparam logic [NUM_BUTTONS-1:0] IDLE_RAW = ACTIVE_LOW ? {NUM_BUTTONS{1'b1}}
                                                           : {NUM_BUTTONS{1'b0}};
  localparam logic [CNT_WIDTH-1:0]   CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);

  logic [NUM_BUTTONS-1:0] sync_meta;
  logic [NUM_BUTTONS-1:0] sync_out;
  logic [NUM_BUTTONS-1:0] sample;
  logic [NUM_BUTTONS-1:0] cap_set;
  logic [NUM_BUTTONS-1:0] cap_q;

  // Synchronizer idles at the unpressed pin value so reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= IDLE_RAW;
      sync_out  <= IDLE_RAW;
    end else begin
      sync_meta <= button_in;
      sync_out  <= sync_meta;
    end
  end

  assign sample = sync_out ^ {NUM_BUTTONS{ACTIVE_LOW}};

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 level_q;
    logic                 press_q;
    logic                 release_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state     <= ST_STABLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state)
          ST_STABLE: begin
            cnt <= '0;
            if (sample[i] != level_q) begin
              state <= ST_COUNTING;
            end
          end
          ST_COUNTING: begin
            if (sample[i] == level_q) begin
              state <= ST_STABLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              // Stable long enough: accept the new level and strobe once.
              level_q   <= sample[i];
              press_q   <= sample[i];
              release_q <= ~sample[i];
              state     <= ST_STABLE;
              cnt       <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= ST_STABLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign button_level[i]  = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
  end

  assign cap_set = press_pulse | (CAPTURE_RELEASE ? release_pulse : {NUM_BUTTONS{1'b0}});

  // Set has priority over clear so an event landing on a clear is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= '0;
    end else begin
      cap_q <= (cap_q & ~edge_clear) | cap_set;
    end
  end

  assign edge_capture = cap_q;
  assign irq          = |cap_q;

endmodule

// File: tb/tb_button_debounce_capture.sv
// Directed bench for button_debounce_capture: two instances (release capture
// off/on) checked every cycle against a sliding-window model plus literal checks.
module tb_button_debounce_capture;

  localparam int NB = 4;
  localparam int D  = 16;
  localparam int CW = 4;
  localparam int L  = D + 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] button_in = '1;
  logic [NB-1:0] edge_clear = '0;

  logic [NB-1:0] level_a, press_a, rel_a, cap_a;
  logic [NB-1:0] level_b, press_b, rel_b, cap_b;
  logic          irq_a, irq_b;

  button_debounce_capture #(
    .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW),
    .ACTIVE_LOW(1'b1), .CAPTURE_RELEASE(1'b0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .button_in(button_in),
    .button_level(level_a), .press_pulse(press_a), .release_pulse(rel_a),
    .edge_capture(cap_a), .edge_clear(edge_clear), .irq(irq_a)
  );

  button_debounce_capture #(
    .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW),
    .ACTIVE_LOW(1'b1), .CAPTURE_RELEASE(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .button_in(button_in),
    .button_level(level_b), .press_pulse(press_b), .release_pulse(rel_b),
    .edge_capture(cap_b), .edge_clear(edge_clear), .irq(irq_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: the level flips once the last D+1 normalized samples seen by the
  // debouncer all disagree with it; samples trail the pin by two edges.
  bit [NB-1:0] raw1_m, raw2_m, s_now;
  bit          shist [NB][D+1];
  bit [NB-1:0] lvl_m, prs_m, rel_m, cap_a_m, cap_b_m;
  bit          all_diff;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw1_m = '1; raw2_m = '1;
      lvl_m = '0; prs_m = '0; rel_m = '0; cap_a_m = '0; cap_b_m = '0;
      for (int c = 0; c < NB; c++)
        for (int k = 0; k <= D; k++) shist[c][k] = 1'b0;
    end else begin
      s_now   = ~raw2_m;
      cap_a_m = (cap_a_m & ~edge_clear) | prs_m;
      cap_b_m = (cap_b_m & ~edge_clear) | prs_m | rel_m;
      prs_m   = '0;
      rel_m   = '0;
      for (int c = 0; c < NB; c++) begin
        for (int k = 0; k < D; k++) shist[c][k] = shist[c][k+1];
        shist[c][D] = s_now[c];
        all_diff = 1'b1;
        for (int k = 0; k <= D; k++)
          if (shist[c][k] == lvl_m[c]) all_diff = 1'b0;
        if (all_diff) begin
          lvl_m[c] = ~lvl_m[c];
          if (lvl_m[c]) prs_m[c] = 1'b1;
          else          rel_m[c] = 1'b1;
        end
      end
      raw2_m = raw1_m;
      raw1_m = button_in;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("level_a",   32'(level_a), 32'(lvl_m));
      check("press_a",   32'(press_a), 32'(prs_m));
      check("release_a", 32'(rel_a),   32'(rel_m));
      check("capture_a", 32'(cap_a),   32'(cap_a_m));
      check("irq_a",     32'(irq_a),   32'(|cap_a_m));
      check("level_b",   32'(level_b), 32'(lvl_m));
      check("press_b",   32'(press_b), 32'(prs_m));
      check("release_b", 32'(rel_b),   32'(rel_m));
      check("capture_b", 32'(cap_b),   32'(cap_b_m));
      check("irq_b",     32'(irq_b),   32'(|cap_b_m));
    end
  end

  int prs_cnt [NB];
  int rel_cnt [NB];

  always @(negedge clk) begin
    if (reset_n) begin
      for (int c = 0; c < NB; c++) begin
        if (press_a[c]) prs_cnt[c]++;
        if (rel_a[c])   rel_cnt[c]++;
      end
    end
  end

  task automatic clr_counts();
    for (int c = 0; c < NB; c++) begin
      prs_cnt[c] = 0;
      rel_cnt[c] = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns the cycle of the first negedge where the channel's level (sel=0)
  // or press pulse (sel=1) equals want; -1 if the budget runs out.
  task automatic wait_out(input int ch, input bit want, input int sel, output int at);
    at = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (((sel == 0) ? level_a[ch] : press_a[ch]) == want) begin
        at = cyc;
        break;
      end
    end
  endtask

  int c0, at;

  initial begin
    clr_counts();
    tick(3);
    check("reset_level",   32'(level_a | level_b), 32'd0);
    check("reset_pulses",  32'(press_a | rel_a | press_b | rel_b), 32'd0);
    check("reset_capture", 32'(cap_a | cap_b), 32'd0);
    check("reset_irq",     32'({irq_a, irq_b}), 32'd0);
    reset_n = 1'b1;
    tick(5);

    // Clean press on channel 0
    c0 = cyc;
    button_in[0] = 1'b0;
    wait_out(0, 1'b1, 0, at);
    check("press_latency", 32'(at), 32'(c0 + L));
    check("press_pulse_on", 32'(press_a), 32'b0001);
    check("capture_before", 32'(cap_a), 32'd0);
    @(negedge clk);
    check("press_pulse_off", 32'(press_a), 32'd0);
    check("capture_after", 32'(cap_a), 32'b0001);
    check("irq_after", 32'(irq_a), 32'd1);
    check("other_levels", 32'(level_a & 4'b1110), 32'd0);
    tick(30);

    // Bounce on channel 2: twelve 5-cycle segments, then held pressed
    clr_counts();
    c0 = cyc;
    for (int seg = 0; seg < 12; seg++) begin
      button_in[2] = (seg % 2 == 1);
      tick(5);
    end
    check("bounce_duration", 32'(cyc), 32'(c0 + 60));
    c0 = cyc;
    button_in[2] = 1'b0;
    wait_out(2, 1'b1, 0, at);
    check("bounce_latency", 32'(at), 32'(c0 + L));
    tick(10);
    check("bounce_presses", 32'(prs_cnt[2]), 32'd1);
    check("bounce_releases", 32'(rel_cnt[2]), 32'd0);

    // Glitch on channel 1 shorter than the debounce window
    clr_counts();
    button_in[1] = 1'b0;
    tick(12);
    button_in[1] = 1'b1;
    tick(40);
    check("glitch_level", 32'(level_a[1]), 32'd0);
    check("glitch_presses", 32'(prs_cnt[1]), 32'd0);
    check("glitch_releases", 32'(rel_cnt[1]), 32'd0);
    check("glitch_capture", 32'({cap_a[1], cap_b[1]}), 32'd0);

    // Clear coinciding with a press on channel 3
    edge_clear = '1;
    tick(1);
    edge_clear = '0;
    tick(1);
    check("cleared_all", 32'(cap_a), 32'd0);
    c0 = cyc;
    button_in[3] = 1'b0;
    tick(L);
    check("ch3_pulse_visible", 32'(press_a[3]), 32'd1);
    edge_clear[3] = 1'b1;
    tick(1);
    edge_clear = '0;
    check("set_beats_clear", 32'(cap_a), 32'b1000);
    tick(3);
    edge_clear[3] = 1'b1;
    tick(1);
    edge_clear = '0;
    check("later_clear_cap", 32'(cap_a), 32'd0);
    check("later_clear_irq", 32'(irq_a), 32'd0);
    tick(5);

    // Release of channel 0: captured only when release capture is enabled
    c0 = cyc;
    button_in[0] = 1'b1;
    wait_out(0, 1'b0, 0, at);
    check("release_latency", 32'(at), 32'(c0 + L));
    check("release_pulse_on", 32'(rel_a), 32'b0001);
    @(negedge clk);
    check("release_pulse_off", 32'(rel_a), 32'd0);
    check("release_cap_off", 32'(cap_a), 32'd0);
    check("release_cap_on", 32'(cap_b), 32'b0001);
    check("release_irq", 32'({irq_a, irq_b}), 32'b01);
    tick(10);

    // Reset mid-count with buttons held
    c0 = cyc;
    button_in[0] = 1'b0;
    tick(10);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_level", 32'(level_a | level_b), 32'd0);
    check("midrst_capture", 32'(cap_a | cap_b), 32'd0);
    check("midrst_irq", 32'({irq_a, irq_b}), 32'd0);
    tick(3);
    reset_n = 1'b1;
    c0 = cyc;
    wait_out(0, 1'b1, 1, at);
    check("post_reset_latency", 32'(at), 32'(c0 + L));
    check("post_reset_presses", 32'(press_a), 32'b1101);
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
